iecdrv_trackbuf: RTL and testbench
==================================

Name: iecdrv_trackbuf

Overview:
Parametrised track buffer for the drive's GCR track image. A byte-wide host/loader port and a DRVW-bit drive-head port share one inferred single-port byte RAM through an internal arbiter. The block adds things the plain memories lack:
- a rotating head pointer with programmable track length and index pulse
- read-modify-write for sub-byte drive writes
- dirty tracking of the modified byte range, so the loader writes back only what changed

Parameters:
ADDRWIDTH, 13, byte address width; capacity is 2^ADDRWIDTH bytes.
DRVW, 1, bits per drive step; legal values are 1, 2, 4, 8.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
track_len  in  ADDRWIDTH+3  track length in bits; must be a multiple of DRVW; 0 means 2^(ADDRWIDTH+3)
drv_ce  in  1  one-cycle drive step strobe
drv_we  in  1  the step writes drv_din (sampled with drv_ce)
drv_din  in  DRVW  data written at the head
drv_dout  out  DRVW  data read at the head
drv_valid  out  1  one-cycle pulse; drv_dout is valid
head_pos  out  ADDRWIDTH+3  current bit position
index  out  1  one-cycle pulse on head wrap
overrun  out  1  sticky; a drive step was lost
host_req  in  1  level request, held until host_ack
host_we  in  1  write request
host_addr  in  ADDRWIDTH  byte address
host_din  in  8  write data
host_dout  out  8  read data, valid with host_ack
host_ack  out  1  one-cycle completion pulse
dirty  out  1  a drive write has occurred since the last clear
dirty_lo  out  ADDRWIDTH  lowest modified byte address
dirty_hi  out  ADDRWIDTH  highest modified byte address
dirty_clr  in  1  clears dirty, overrun and the dirty range

Behaviour:
- Reset values: all outputs 0; head_pos = 0; FSM in IDLE; pending step cleared.
- RAM: single port with registered read. The address is registered in the grant cycle and q is available the next cycle.
- FSM states: IDLE, DRV_RD, DRV_WR, HOST_RD, HOST_WR.
- IDLE:
  - drive priority: a drive step (pending or drv_ce) goes to DRV_RD;
  - otherwise host_req goes to HOST_RD or HOST_WR;
  - host_addr, host_din and host_we are captured at grant.
- DRV_RD:
  - chunk = ram[head_pos[ADDRWIDTH+2:3]][head_pos[2:0] +: DRVW];
  - drv_dout = chunk and drv_valid pulses;
  - if drv_we, go to DRV_WR; else advance the head and return to IDLE.
- DRV_WR:
  - write the merged byte (only the chunk bits replaced);
  - update dirty and the range;
  - advance the head and return to IDLE.
  - Latency from drv_ce in IDLE: drv_valid at +2 cycles; head updates at +2 (read) or +3 (write).
- Head advance:
  - if head_pos + DRVW >= effective track_len (computed at ADDRWIDTH+4 bits, no overflow), head_pos = 0 and index pulses;
  - otherwise head_pos += DRVW.
  - Shrinking track_len below head_pos causes a wrap on the next advance.
- Drive pending buffer:
  - drv_ce while the FSM is busy is latched in a 1-deep buffer together with drv_we and drv_din;
  - a further drv_ce while the buffer is full is dropped and sets overrun.
  - The drive must keep drv_ce at least 4 cycles apart.
- HOST_RD: host_dout = q and host_ack pulses; 2 cycles after grant.
- HOST_WR: the write is issued at grant and host_ack pulses the next cycle. Host writes never touch dirty.
- Host starvation: the host is served whenever IDLE has no drive step. With 4-cycle drv_ce spacing, the host completes within 6 cycles of host_req.
- Dirty range:
  - the first write after a clear sets lo = hi = byte;
  - later writes do lo = min(lo, byte) and hi = max(hi, byte).
- dirty_clr coinciding with a DRV_WR commit: the write wins. Result is dirty = 1 and lo = hi = that byte.
- host_req deasserted before ack: illegal; no behaviour is guaranteed.
- Reset mid-operation: any in-flight RAM write may or may not complete. All control state returns to reset values. RAM contents are not cleared.

Decomposition:
- Package iecdrv_pkg holds:
  - the trackbuf_state_t enum (IDLE, DRV_RD, DRV_WR, HOST_RD, HOST_WR);
  - a function to merge a DRVW-bit chunk into a byte.
- One sub-module, iecdrv_spram: single-port byte RAM, registered read, new-data-on-write.

Test Plan:
1. DRVW=1, track_len=16, idle drive: issue 16 drv_ce strobes 5 cycles apart -> head_pos counts 0..15 then 0; index pulses exactly once, on the 16th step; drv_valid 2 cycles after each drv_ce.
2. Host write 0xA5 to addr 3, then DRVW=2 with head at bit 24 writes 2'b10 -> host read of addr 3 returns 0xA6; dirty = 1; dirty_lo = dirty_hi = 3.
3. Drive writes at bytes 7, 2, 9 -> dirty_lo = 2, dirty_hi = 9. Assert dirty_clr in the same cycle as a DRV_WR commit at byte 5 -> dirty = 1, lo = hi = 5.
4. host_req issued in the same cycle as drv_ce -> drive is served first; host_ack arrives at most 5 cycles later with the correct data.
5. Three drv_ce strobes on consecutive cycles -> two steps complete, overrun = 1; dirty_clr returns overrun to 0.
6. Assert reset during DRV_WR -> head_pos = 0, outputs = 0, FSM = IDLE; a subsequent host read at an untouched address returns its prior data.

Source files
------------

// File: rtl/iecdrv_pkg.sv
// Shared types and helpers for the drive track buffer.
//   trackbuf_state_t : arbiter/sequencer states
//   merge_chunk      : replace a narrow bit field inside a byte
package iecdrv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRV_RD,
    DRV_WR,
    HOST_RD,
    HOST_WR
  } trackbuf_state_t;

  // Replaces 'width' bits of old_byte starting at 'offset' with the low
  // bits of chunk; all other bits of old_byte are preserved.
  function automatic logic [7:0] merge_chunk(input logic [7:0] old_byte,
                                             input logic [7:0] chunk,
                                             input logic [2:0] offset,
                                             input logic [3:0] width);
    logic [8:0] wide_mask;
    logic [7:0] mask;
    wide_mask = (9'd1 << width) - 9'd1;
    mask      = wide_mask[7:0] << offset;
    return (old_byte & ~mask) | ((chunk << offset) & mask);
  endfunction

endpackage

// File: rtl/iecdrv_spram.sv
// Single-port byte RAM with registered read and new-data-on-write.
//   clk  : clock
//   we   : write enable
//   addr : byte address, sampled on the clock edge
//   din  : write data
//   q    : read data for the address presented on the previous edge
module iecdrv_spram #(
  parameter int ADDRWIDTH = 13
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           q
);

  logic [7:0] mem [2**ADDRWIDTH];

  // Contents survive reset on purpose, so there is no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      q         <= din;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/iecdrv_trackbuf.sv
// GCR track buffer shared between a byte-wide host port and a DRVW-bit
// drive-head port, with a rotating head, read-modify-write for narrow
// drive writes and tracking of the modified byte range.
//   clk, reset                : clock, async active-high reset
//   track_len                 : track length in bits (0 = full capacity)
//   drv_ce/drv_we/drv_din     : drive step strobe, write flag, write data
//   drv_dout/drv_valid        : data under the head, one-cycle valid
//   head_pos/index/overrun    : head bit position, wrap pulse, lost step
//   host_req/we/addr/din      : host request (held until host_ack)
//   host_dout/host_ack        : host read data, completion pulse
//   dirty/dirty_lo/dirty_hi   : drive-modified byte range
//   dirty_clr                 : clears dirty, range and overrun
module iecdrv_trackbuf
  import iecdrv_pkg::*;
#(
  parameter int ADDRWIDTH = 13,
  parameter int DRVW      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH+2:0] track_len,
  input  logic                 drv_ce,
  input  logic                 drv_we,
  input  logic [DRVW-1:0]      drv_din,
  output logic [DRVW-1:0]      drv_dout,
  output logic                 drv_valid,
  output logic [ADDRWIDTH+2:0] head_pos,
  output logic                 index,
  output logic                 overrun,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDRWIDTH-1:0] host_addr,
  input  logic [7:0]           host_din,
  output logic [7:0]           host_dout,
  output logic                 host_ack,
  output logic                 dirty,
  output logic [ADDRWIDTH-1:0] dirty_lo,
  output logic [ADDRWIDTH-1:0] dirty_hi,
  input  logic                 dirty_clr
);

  localparam int PW = ADDRWIDTH + 3;
  localparam int SW = ADDRWIDTH + 4;

  trackbuf_state_t state, next_state;

  logic                 pend_valid, pend_we;
  logic [DRVW-1:0]      pend_din;
  logic                 cur_we;
  logic [DRVW-1:0]      cur_din;
  logic                 step_req, step_we;
  logic [DRVW-1:0]      step_din;
  logic                 grant_drv, grant_host, advance;
  logic                 ram_we;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [7:0]           ram_din, ram_q, merged, q_shift;
  logic [ADDRWIDTH-1:0] head_byte;
  logic [2:0]           head_off;
  logic [SW-1:0]        next_sum, eff_len;
  logic                 wrap;

  assign head_byte = head_pos[PW-1:3];
  assign head_off  = head_pos[2:0];

  // A latched step is always older than a live strobe, so it goes first.
  assign step_req = pend_valid | drv_ce;
  assign step_we  = pend_valid ? pend_we  : drv_we;
  assign step_din = pend_valid ? pend_din : drv_din;

  // One extra bit so head + DRVW never overflows, and so a zero length
  // can stand for the full 2^PW-bit track.
  assign next_sum = {1'b0, head_pos} + SW'(DRVW);
  assign eff_len  = (track_len == '0) ? {1'b1, {PW{1'b0}}} : {1'b0, track_len};
  assign wrap     = (next_sum >= eff_len);

  assign q_shift = ram_q >> head_off;
  assign merged  = merge_chunk(ram_q, 8'(cur_din), head_off, 4'(DRVW));

  iecdrv_spram #(.ADDRWIDTH(ADDRWIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .q    (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // The RAM address defaults to the head byte so q still holds the old
  // byte during DRV_WR. A host read is not re-granted in its own ack
  // cycle, where host_req is legitimately still high.
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_addr   = head_byte;
    ram_din    = merged;
    grant_drv  = 1'b0;
    grant_host = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (step_req) begin
          grant_drv  = 1'b1;
          next_state = DRV_RD;
        end else if (host_req && !host_ack) begin
          grant_host = 1'b1;
          ram_addr   = host_addr;
          if (host_we) begin
            ram_we     = 1'b1;
            ram_din    = host_din;
            next_state = HOST_WR;
          end else begin
            next_state = HOST_RD;
          end
        end
      end
      DRV_RD: begin
        if (cur_we) begin
          next_state = DRV_WR;
        end else begin
          advance    = 1'b1;
          next_state = IDLE;
        end
      end
      DRV_WR: begin
        ram_we     = 1'b1;
        advance    = 1'b1;
        next_state = IDLE;
      end
      HOST_RD, HOST_WR: next_state = IDLE;
      default:          next_state = IDLE;
    endcase
  end

  // Pending step buffer: one step may wait while the sequencer is busy;
  // a second one arriving meanwhile is lost and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_din   <= '0;
      overrun    <= 1'b0;
      cur_we     <= 1'b0;
      cur_din    <= '0;
    end else begin
      if (dirty_clr) overrun <= 1'b0;
      if (grant_drv) begin
        cur_we  <= step_we;
        cur_din <= step_din;
      end
      if (state == IDLE) begin
        if (pend_valid && !drv_ce) begin
          pend_valid <= 1'b0;
        end else if (pend_valid && drv_ce) begin
          pend_we  <= drv_we;
          pend_din <= drv_din;
        end
      end else if (drv_ce) begin
        if (pend_valid) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_we    <= drv_we;
          pend_din   <= drv_din;
        end
      end
    end
  end

  // Head, drive read data and host completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_pos  <= '0;
      index     <= 1'b0;
      drv_valid <= 1'b0;
      drv_dout  <= '0;
      host_ack  <= 1'b0;
      host_dout <= '0;
    end else begin
      index     <= 1'b0;
      drv_valid <= 1'b0;
      host_ack  <= 1'b0;
      if (state == DRV_RD) begin
        drv_valid <= 1'b1;
        drv_dout  <= q_shift[DRVW-1:0];
      end
      if (advance) begin
        if (wrap) begin
          head_pos <= '0;
          index    <= 1'b1;
        end else begin
          head_pos <= next_sum[PW-1:0];
        end
      end
      if (state == HOST_RD) begin
        host_ack  <= 1'b1;
        host_dout <= ram_q;
      end
      if (grant_host && host_we) host_ack <= 1'b1;
    end
  end

  // Dirty range; a commit in the same cycle as a clear restarts the range
  // at the committed byte instead of being lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty    <= 1'b0;
      dirty_lo <= '0;
      dirty_hi <= '0;
    end else if (state == DRV_WR) begin
      dirty <= 1'b1;
      if (!dirty || dirty_clr) begin
        dirty_lo <= head_byte;
        dirty_hi <= head_byte;
      end else begin
        if (head_byte < dirty_lo) dirty_lo <= head_byte;
        if (head_byte > dirty_hi) dirty_hi <= head_byte;
      end
    end else if (dirty_clr) begin
      dirty    <= 1'b0;
      dirty_lo <= '0;
      dirty_hi <= '0;
    end
  end

endmodule

// File: tb/tb_iecdrv_trackbuf.sv
// Directed self-checking bench for iecdrv_trackbuf (ADDRWIDTH=13, DRVW=2).
module tb_iecdrv_trackbuf;

  localparam int AW = 13;
  localparam int DW = 2;
  localparam int PW = AW + 3;

  logic          clk, reset;
  logic [PW-1:0] track_len;
  logic          drv_ce, drv_we;
  logic [DW-1:0] drv_din, drv_dout;
  logic          drv_valid;
  logic [PW-1:0] head_pos;
  logic          index, overrun;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_din, host_dout;
  logic          host_ack, dirty;
  logic [AW-1:0] dirty_lo, dirty_hi;
  logic          dirty_clr;

  int checks = 0;
  int errors = 0;

  iecdrv_trackbuf #(.ADDRWIDTH(AW), .DRVW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .track_len (track_len),
    .drv_ce    (drv_ce),
    .drv_we    (drv_we),
    .drv_din   (drv_din),
    .drv_dout  (drv_dout),
    .drv_valid (drv_valid),
    .head_pos  (head_pos),
    .index     (index),
    .overrun   (overrun),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_dout (host_dout),
    .host_ack  (host_ack),
    .dirty     (dirty),
    .dirty_lo  (dirty_lo),
    .dirty_hi  (dirty_hi),
    .dirty_clr (dirty_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One drive step starting now (1 time unit after an edge); returns
  // drv_valid at +1/+2, drv_dout at +2 and head/index once updated
  // (+2 read, +3 write). Returns 5 cycles after the strobe.
  task automatic applyStimulus(input logic we, input logic [DW-1:0] din,
                               output logic [1:0] valid_seq,
                               output logic [DW-1:0] dout,
                               output logic idx, output logic [PW-1:0] head);
    drv_ce = 1'b1; drv_we = we; drv_din = din;
    tick;
    drv_ce = 1'b0; drv_we = 1'b0;
    @(negedge clk); valid_seq[1] = drv_valid;
    tick;
    @(negedge clk); valid_seq[0] = drv_valid; dout = drv_dout;
    if (!we) begin
      idx = index; head = head_pos;
      tick; tick; tick;
    end else begin
      tick;
      @(negedge clk); idx = index; head = head_pos;
      tick; tick;
    end
  endtask

  task automatic advanceHead(input int n, output logic [PW-1:0] head);
    logic [1:0] vs; logic [DW-1:0] d; logic ix;
    head = '0;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, vs, d, ix, head);
  endtask

  // Host transfer; lat = negedges from request to ack, -1 on timeout.
  task automatic hostXfer(input logic we, input logic [AW-1:0] addr,
                          input logic [7:0] din, output logic [7:0] dout,
                          output int lat);
    host_req = 1'b1; host_we = we; host_addr = addr; host_din = din;
    lat = -1; dout = '0;
    for (int c = 0; c < 10 && lat < 0; c++) begin
      @(negedge clk);
      if (host_ack) begin lat = c; dout = host_dout; end
      tick;
    end
    host_req = 1'b0; host_we = 1'b0;
  endtask

  initial begin
    logic [1:0]    vs;
    logic [DW-1:0] d;
    logic          ix, got, vld2;
    logic [PW-1:0] hd;
    logic [7:0]    rd;
    int            lat, vcount;

    reset = 1'b1; track_len = 16'd32;
    drv_ce = 0; drv_we = 0; drv_din = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_din = 0; dirty_clr = 0;
    tick; tick; tick;
    reset = 1'b0;
    tick;
    @(negedge clk);
    checkOutput("rst_head", 32'(head_pos), 32'd0);
    checkOutput("rst_flags", 32'({drv_valid, index, overrun, host_ack, dirty}), 32'd0);
    checkOutput("rst_range", 32'({dirty_lo, dirty_hi}), 32'd0);
    checkOutput("rst_data", 32'({drv_dout, host_dout}), 32'd0);
    tick;

    // 1: 16 read steps, 2 bits each over a 32-bit track
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 2'b00, vs, d, ix, hd);
      checkOutput($sformatf("t1_valid_%0d", k), 32'(vs), 32'd1);
      checkOutput($sformatf("t1_head_%0d", k), 32'(hd), 32'((2 * k) % 32));
      checkOutput($sformatf("t1_index_%0d", k), 32'(ix), 32'(k == 16));
    end

    // 2: host write 0xA5 to byte 3, drive writes 2'b10 at bit 24
    hostXfer(1'b1, 13'd3, 8'hA5, rd, lat);
    checkOutput("t2_wr_lat", 32'(lat), 32'd1);
    advanceHead(12, hd);
    checkOutput("t2_head24", 32'(hd), 32'd24);
    applyStimulus(1'b1, 2'b10, vs, d, ix, hd);
    checkOutput("t2_old_chunk", 32'(d), 32'd1);
    checkOutput("t2_head26", 32'(hd), 32'd26);
    hostXfer(1'b0, 13'd3, 8'h00, rd, lat);
    checkOutput("t2_rd_lat", 32'(lat), 32'd2);
    checkOutput("t2_rd_data", 32'(rd), 32'hA6);
    checkOutput("t2_dirty", 32'({dirty, dirty_lo, dirty_hi}), 32'({1'b1, 13'd3, 13'd3}));

    // 3: dirty range across writes at bytes 7, 2, 9
    dirty_clr = 1'b1;
    tick;
    dirty_clr = 1'b0;
    @(negedge clk);
    checkOutput("t3_clear", 32'({dirty, dirty_lo, dirty_hi}), 32'd0);
    tick;
    track_len = 16'd96;
    advanceHead(15, hd);
    checkOutput("t3_head56", 32'(hd), 32'd56);
    applyStimulus(1'b1, 2'b11, vs, d, ix, hd);
    checkOutput("t3_rng7", 32'({dirty, dirty_lo, dirty_hi}), 32'({1'b1, 13'd7, 13'd7}));
    advanceHead(27, hd);
    checkOutput("t3_head16", 32'(hd), 32'd16);
    applyStimulus(1'b1, 2'b11, vs, d, ix, hd);
    checkOutput("t3_rng2", 32'({dirty_lo, dirty_hi}), 32'({13'd2, 13'd7}));
    advanceHead(27, hd);
    checkOutput("t3_head72", 32'(hd), 32'd72);
    applyStimulus(1'b1, 2'b11, vs, d, ix, hd);
    checkOutput("t3_rng9", 32'({dirty_lo, dirty_hi}), 32'({13'd2, 13'd9}));
    checkOutput("t3_head74", 32'(hd), 32'd74);
    // track shrunk below the head: next advance wraps
    track_len = 16'd40;
    applyStimulus(1'b0, 2'b00, vs, d, ix, hd);
    checkOutput("t3_shrink_head", 32'(hd), 32'd0);
    checkOutput("t3_shrink_index", 32'(ix), 32'd1);
    track_len = 16'd96;
    advanceHead(20, hd);
    checkOutput("t3_head40", 32'(hd), 32'd40);
    // clear lands in the DRV_WR cycle of a write to byte 5
    drv_ce = 1'b1; drv_we = 1'b1; drv_din = 2'b01;
    tick;
    drv_ce = 1'b0; drv_we = 1'b0;
    tick;
    dirty_clr = 1'b1;
    tick;
    dirty_clr = 1'b0;
    @(negedge clk);
    checkOutput("t3_clr_commit", 32'({dirty, dirty_lo, dirty_hi}), 32'({1'b1, 13'd5, 13'd5}));
    checkOutput("t3_head42", 32'(head_pos), 32'd42);
    tick; tick;

    // 4: host and drive request together; drive first
    drv_ce = 1'b1; drv_we = 1'b1; drv_din = 2'b11;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd3;
    got = 1'b0; lat = 99; vld2 = 1'b0; rd = '0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (c == 2) vld2 = drv_valid;
      if (host_ack) begin got = 1'b1; lat = c; rd = host_dout; end
      tick;
      drv_ce = 1'b0; drv_we = 1'b0;
      if (got) host_req = 1'b0;
    end
    host_req = 1'b0;
    checkOutput("t4_drive_first", 32'(vld2), 32'd1);
    checkOutput("t4_host_latency", 32'(got && lat <= 5), 32'd1);
    checkOutput("t4_host_data", 32'(rd), 32'hA6);
    tick; tick;

    // 5: three back-to-back write strobes, third one is lost
    hostXfer(1'b1, 13'd5, 8'h00, rd, lat);
    checkOutput("t5_wr_lat", 32'(lat), 32'd1);
    vcount = 0;
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        drv_ce = 1'b1; drv_we = 1'b1;
        drv_din = (c == 0) ? 2'b11 : (c == 1) ? 2'b01 : 2'b10;
      end else begin
        drv_ce = 1'b0; drv_we = 1'b0;
      end
      @(negedge clk);
      if (drv_valid) vcount++;
      tick;
    end
    checkOutput("t5_steps", 32'(vcount), 32'd2);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    checkOutput("t5_head48", 32'(head_pos), 32'd48);
    hostXfer(1'b0, 13'd5, 8'h00, rd, lat);
    checkOutput("t5_byte5", 32'(rd), 32'h70);
    dirty_clr = 1'b1;
    tick;
    dirty_clr = 1'b0;
    @(negedge clk);
    checkOutput("t5_overrun_clr", 32'({overrun, dirty}), 32'd0);
    tick;

    // 6: reset during DRV_WR
    hostXfer(1'b1, 13'd20, 8'h3C, rd, lat);
    tick; tick; tick;
    drv_ce = 1'b1; drv_we = 1'b1; drv_din = 2'b11;
    tick;
    drv_ce = 1'b0; drv_we = 1'b0;
    tick;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_head", 32'(head_pos), 32'd0);
    checkOutput("t6_flags", 32'({drv_valid, index, overrun, host_ack, dirty}), 32'd0);
    checkOutput("t6_data", 32'({drv_dout, host_dout, dirty_lo, dirty_hi}), 32'd0);
    tick; tick;
    reset = 1'b0;
    tick;
    hostXfer(1'b0, 13'd20, 8'h00, rd, lat);
    checkOutput("t6_rd_lat", 32'(lat), 32'd2);
    checkOutput("t6_rd_data", 32'(rd), 32'h3C);
    applyStimulus(1'b0, 2'b00, vs, d, ix, hd);
    checkOutput("t6_step_head", 32'(hd), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
